spi_reg_decoder: RTL and testbench
==================================

# spi_reg_decoder

Command decoder and register file sitting directly downstream of the SPI slave. It parses the byte stream the slave delivers (`i_RX_DV`/`i_RX_Byte`) into read and write frames against a 16 x 16-bit register file. It returns read data to the slave's 16-bit transmit register (`o_TX_DV`/`o_TX_Byte`) so that the data is shifted out on MISO in the following frame. Everything runs in the `i_Clk` domain; only `i_SPI_CS_n` is asynchronous and is synchronized internally.

## Interface
- `ID_VALUE`, default 16'h5A01: read-only contents of register 15.
- `i_Clk` input 1: system clock, the only clock.
- `i_Rst` input 1: asynchronous, active-high reset.
- `i_RX_DV` input 1: one-cycle pulse; `i_RX_Byte` is valid.
- `i_RX_Byte` input 8: received byte, MSB first on the wire.
- `i_SPI_CS_n` input 1: raw SPI chip select, asynchronous, active low.
- `o_TX_DV` output 1: one-cycle pulse loading `o_TX_Byte` into the slave.
- `o_TX_Byte` output 16: word shifted out during the next frame.
- `o_Regs` output 224: registers 0..13 flattened; reg n occupies bits [16n+15:16n].
- `o_Wr_Strobe` output 1: one-cycle pulse on every accepted write.
- `o_Wr_Addr` output 4: address of the last accepted write.
- `o_Frame_Err` output 1: one-cycle pulse when a frame is aborted.

## Operation
- **CS synchronizer:** 2-flop synchronizer plus 1 edge-detect flop, all reset to 1.
  - A frame starts on a synchronized falling edge.
  - A frame ends on a synchronized rising edge.
- **Command byte** (first byte of a frame): {RW, RSV[2:0], ADDR[3:0]}.
  - RW=1 is a read; RW=0 is a write.
  - RSV must be 000.
- **State machine** (states IDLE, CMD, WDATA_H, WDATA_L, DONE):
  - IDLE → CMD on CS falling edge.
  - CMD + byte, RSV≠0 → DONE, error flag set.
  - CMD + byte, read → hold ← reg[ADDR], then → DONE.
  - CMD + byte, write → WDATA_H; latch ADDR.
  - WDATA_H + byte → latch data[15:8], then → WDATA_L.
  - WDATA_L + byte → perform the write with {data_h, byte}, pulse `o_Wr_Strobe`, set hold ← new value, then → DONE.
  - DONE + byte → byte ignored.
  - Any state + CS rising edge → IDLE.
  - Frame end in WDATA_H or WDATA_L is a short write: no write, hold unchanged, error flag set.
- **Frame end actions:**
  - If at least one byte was received, pulse `o_TX_DV` with `o_TX_Byte` ← hold.
  - If the error flag is set, pulse `o_Frame_Err` and increment ERR_CNT.
  - If at least one byte was received, increment FRM_CNT.
  - A frame with zero bytes produces no TX_DV, no count and no error.
- **Registers:**
  - Regs 0..13 are read/write.
  - Reg 14 is read-only {ERR_CNT[7:0], FRM_CNT[7:0]}; both counters wrap 8'hFF → 8'h00.
  - Reg 15 is read-only `ID_VALUE`.
  - A write to 14 or 15 is accepted as a frame (no error, strobe still pulses) but does not change contents; hold ← the current read value.
- **Simultaneous events:** if `i_RX_DV` and the CS rising edge occur in the same cycle, the byte is processed first, then the frame end using the updated state.
- **CS falling edge outside IDLE** (missed rising edge): behave as end-then-start. The frame-end actions run and the FSM goes to CMD.

## Timing
- **Reset values:**
  - All registers 0, hold 0, counters 0, state IDLE.
  - `o_TX_Byte`=0, `o_TX_DV`=0, `o_Wr_Strobe`=0, `o_Frame_Err`=0, `o_Wr_Addr`=0.
- **Reset mid-frame:** aborts immediately. No count and no TX_DV until a fresh CS falling edge is seen after reset deasserts.
- **Write latency:** `o_Regs`, `o_Wr_Strobe` and `o_Wr_Addr` all update on the clock edge after the `i_RX_DV` of the last data byte, so the strobe and the new data are coincident.
- **Hold capture:** occurs on the clock edge after the command byte's `i_RX_DV`.
- **Frame-end latency:** `o_TX_DV` and `o_Frame_Err` assert 3 `i_Clk` cycles after `i_SPI_CS_n` rises (2 sync + edge), for exactly 1 cycle.
- **Master timing requirements:**
  - Keep CS high for at least 4 `i_Clk` cycles between frames.
  - Keep CS low for at least 4 `i_Clk` cycles after the last SCK edge, so the final RX_DV is not lost.
- **Read protocol:** a read is pipelined. The read frame returns the previous hold; the next frame's first 16 bits carry reg[ADDR].

## Test plan
- **Write then read:** after reset, send frame {0x03, 0xBE, 0xEF}, then frame {0x83}, then an empty-content frame.
  - Strobe pulses with `o_Wr_Addr`=3 and `o_Regs[63:48]`=16'hBEEF.
  - TX_DV pulses after frame 1 with 16'hBEEF, and after frame 2 with 16'hBEEF.
  - Reg 14 reads 16'h0002 after two counted frames.
- **Short write:** send frame {0x05, 0x12}, end.
  - No strobe, reg 5 stays 0, `o_Frame_Err` pulses, ERR_CNT=1, and no change to `o_TX_Byte`.
- **Reserved bits:** command 0x91 → error pulse, hold unchanged. Command 0x8F → next TX word is 16'h5A01.
- **Read-only write:** frame {0x0F, 0x00, 0x00} → strobe with addr 15, reg 15 still 16'h5A01, no error.
- **Counter wrap:** run 256 valid frames → FRM_CNT reads 8'h00. Extra bytes after a completed write are ignored: {0x01, 0x11, 0x22, 0x33} gives reg1=16'h1122.
- **Corner cases:**
  - `i_RX_DV` of the last byte in the same cycle as the CS edge detect → the write still lands before frame end.
  - Assert `i_Rst` mid-write → all outputs 0 next cycle, and no TX_DV.

Source files
------------

// File: rtl/spi_reg_decoder_if.sv
// Byte-level link between the SPI slave core and the register decoder.
// Latency: none; this is wiring only.
// Backpressure: none; RX and TX are single-cycle pulses with no ready signal.
//
// Signals:
//   i_RX_DV / i_RX_Byte : received byte pulse and data (slave core -> decoder)
//   o_TX_DV / o_TX_Byte : transmit word load pulse and data (decoder -> slave core)
interface spi_reg_decoder_if;
    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic        o_TX_DV;
    logic [15:0] o_TX_Byte;

    // master: the SPI slave core side, which delivers bytes and takes TX words
    modport master (
        output i_RX_DV,
        output i_RX_Byte,
        input  o_TX_DV,
        input  o_TX_Byte
    );

    // slave: the decoder side
    modport slave (
        input  i_RX_DV,
        input  i_RX_Byte,
        output o_TX_DV,
        output o_TX_Byte
    );
endinterface

// File: rtl/spi_reg_decoder.sv
// Parses SPI command frames into reads/writes of a 16 x 16-bit register file.
// Latency: writes land 1 cycle after the last byte; TX/error pulse 3 cycles after CS rises.
// Backpressure: none; every RX byte is consumed, bytes beyond a complete command are dropped.
//
// Ports:
//   i_Clk, i_Rst     : clock and asynchronous active-high reset
//   byte_if (slave)  : RX byte pulses in, TX word load pulses out
//   i_SPI_CS_n       : raw asynchronous chip select, active low
//   o_Regs           : registers 0..13 flattened, reg n at [16n+15:16n]
//   o_Wr_Strobe      : one-cycle pulse per accepted write, o_Wr_Addr holds its address
//   o_Frame_Err      : one-cycle pulse when a frame ends with an error
module spi_reg_decoder #(
    parameter logic [15:0] ID_VALUE = 16'h5A01
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    spi_reg_decoder_if.slave     byte_if,
    input  logic                 i_SPI_CS_n,
    output logic [223:0]         o_Regs,
    output logic                 o_Wr_Strobe,
    output logic [3:0]           o_Wr_Addr,
    output logic                 o_Frame_Err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA_H,
        WDATA_L,
        DONE
    } state_t;

    localparam int NUM_RW = 14;

    // chip select synchronizer and edge detect
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic cs_fall, cs_rise;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  data_h_q, data_h_d;
    logic        err_flag_q, err_flag_d;
    logic        got_byte_q, got_byte_d;
    logic [15:0] regs_q [NUM_RW];
    logic [15:0] regs_d [NUM_RW];
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  frm_cnt_q, frm_cnt_d;
    logic [15:0] tx_byte_q, tx_byte_d;
    logic        tx_dv_q, tx_dv_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] wdata;
    logic        frame_end;

    assign cs_fall   = cs_prev_q & ~cs_sync_q;
    assign cs_rise   = ~cs_prev_q & cs_sync_q;
    assign wdata     = {data_h_q, byte_if.i_RX_Byte};
    // A fall seen outside IDLE means the rising edge was missed: close the old frame first.
    assign frame_end = cs_rise | (cs_fall & (state_q != IDLE));

    // Read view of the full 16-entry map; counters are read before this frame's increment.
    function automatic logic [15:0] rd_reg(input logic [3:0] a);
        logic [15:0] v;
        if (a < 4'(NUM_RW)) begin
            v = regs_q[a];
        end else if (a == 4'd14) begin
            v = {err_cnt_q, frm_cnt_q};
        end else begin
            v = ID_VALUE;
        end
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        addr_d      = addr_q;
        data_h_d    = data_h_q;
        err_flag_d  = err_flag_q;
        got_byte_d  = got_byte_q;
        regs_d      = regs_q;
        err_cnt_d   = err_cnt_q;
        frm_cnt_d   = frm_cnt_q;
        tx_byte_d   = tx_byte_q;
        wr_addr_d   = wr_addr_q;
        tx_dv_d     = 1'b0;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;

        // Byte handling first so a byte coincident with frame end is not lost.
        if (byte_if.i_RX_DV && (state_q != IDLE)) begin
            got_byte_d = 1'b1;
            case (state_q)
                CMD: begin
                    if (byte_if.i_RX_Byte[6:4] != 3'b000) begin
                        err_flag_d = 1'b1;
                        state_d    = DONE;
                    end else if (byte_if.i_RX_Byte[7]) begin
                        hold_d  = rd_reg(byte_if.i_RX_Byte[3:0]);
                        state_d = DONE;
                    end else begin
                        addr_d  = byte_if.i_RX_Byte[3:0];
                        state_d = WDATA_H;
                    end
                end
                WDATA_H: begin
                    data_h_d = byte_if.i_RX_Byte;
                    state_d  = WDATA_L;
                end
                WDATA_L: begin
                    if (addr_q < 4'(NUM_RW)) begin
                        regs_d[addr_q] = wdata;
                        hold_d         = wdata;
                    end else begin
                        // read-only target: accepted, contents untouched
                        hold_d = rd_reg(addr_q);
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                    state_d     = DONE;
                end
                default: ;
            endcase
        end

        if (frame_end) begin
            // ending mid-data is a short write
            if ((state_d == WDATA_H) || (state_d == WDATA_L)) begin
                err_flag_d = 1'b1;
            end
            if (got_byte_d) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = hold_d;
                frm_cnt_d = frm_cnt_q + 8'd1;
            end
            if (err_flag_d) begin
                frame_err_d = 1'b1;
                err_cnt_d   = err_cnt_q + 8'd1;
            end
            state_d    = IDLE;
            got_byte_d = 1'b0;
            err_flag_d = 1'b0;
        end

        if (cs_fall) begin
            state_d    = CMD;
            got_byte_d = 1'b0;
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            hold_q      <= '0;
            addr_q      <= '0;
            data_h_q    <= '0;
            err_flag_q  <= 1'b0;
            got_byte_q  <= 1'b0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= '0;
            end
            err_cnt_q   <= '0;
            frm_cnt_q   <= '0;
            tx_byte_q   <= '0;
            tx_dv_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cs_meta_q   <= i_SPI_CS_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            state_q     <= state_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            data_h_q    <= data_h_d;
            err_flag_q  <= err_flag_d;
            got_byte_q  <= got_byte_d;
            regs_q      <= regs_d;
            err_cnt_q   <= err_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        o_Regs = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            o_Regs[16*i +: 16] = regs_q[i];
        end
    end

    assign byte_if.o_TX_DV   = tx_dv_q;
    assign byte_if.o_TX_Byte = tx_byte_q;
    assign o_Wr_Strobe       = wr_strobe_q;
    assign o_Wr_Addr         = wr_addr_q;
    assign o_Frame_Err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Bench for spi_reg_decoder: frame-level reference model feeds expected TX words
// and write events into queues; a negedge monitor pops and compares them as the
// DUT produces them, and each scenario task checks register/error state inline.
module tb_spi_reg_decoder;
    localparam logic [15:0] ID = 16'h5A01;

    logic         i_Clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_SPI_CS_n = 1'b1;
    logic [223:0] o_Regs;
    logic         o_Wr_Strobe;
    logic [3:0]   o_Wr_Addr;
    logic         o_Frame_Err;

    spi_reg_decoder_if bus ();

    spi_reg_decoder #(.ID_VALUE(ID)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .byte_if    (bus),
        .i_SPI_CS_n (i_SPI_CS_n),
        .o_Regs     (o_Regs),
        .o_Wr_Strobe(o_Wr_Strobe),
        .o_Wr_Addr  (o_Wr_Addr),
        .o_Frame_Err(o_Frame_Err)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // scoreboard queues and reference model state
    logic [15:0] exp_tx [$];
    logic [19:0] exp_wr [$];
    int          exp_err = 0;
    int          obs_err = 0;
    logic [15:0] m_regs [14];
    logic [7:0]  m_err_cnt, m_frm_cnt;
    logic [15:0] m_hold;

    function automatic logic [15:0] m_rd(input logic [3:0] a);
        if (a < 4'd14) return m_regs[a];
        if (a == 4'd14) return {m_err_cnt, m_frm_cnt};
        return ID;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 14; i++) m_regs[i] = 16'h0;
        m_err_cnt = 8'h0;
        m_frm_cnt = 8'h0;
        m_hold    = 16'h0;
    endtask

    // Frame-level behaviour: what the frame should produce once CS rises.
    task automatic model_frame(input logic [7:0] b [4], input int n);
        logic [3:0] a;
        bit         err;
        if (n == 0) return;
        a   = b[0][3:0];
        err = 1'b0;
        if (b[0][6:4] != 3'b000) begin
            err = 1'b1;
        end else if (b[0][7]) begin
            m_hold = m_rd(a);
        end else if (n < 3) begin
            err = 1'b1;
        end else begin
            if (a < 4'd14) m_regs[a] = {b[1], b[2]};
            m_hold = m_rd(a);
            exp_wr.push_back({a, (a < 4'd14) ? {b[1], b[2]} : 16'h0});
        end
        exp_tx.push_back(m_hold);
        m_frm_cnt = m_frm_cnt + 8'd1;
        if (err) begin
            m_err_cnt = m_err_cnt + 8'd1;
            exp_err++;
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = v;
        tick();
        bus.i_RX_DV   = 1'b0;
    endtask

    // late=1 delivers the last byte in the cycle the CS rising edge is detected.
    task automatic run_frame(input logic [7:0] b [4], input int n, input bit late);
        model_frame(b, n);
        i_SPI_CS_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) begin
            if (late && (i == n - 1)) break;
            send_byte(b[i]);
            repeat (3) tick();
        end
        repeat (4) tick();
        i_SPI_CS_n = 1'b1;
        if (late && (n > 0)) begin
            repeat (2) tick();
            send_byte(b[n-1]);
        end
        repeat (8) tick();
    endtask

    task automatic apply_reset();
        i_Rst = 1'b1;
        repeat (2) tick();
        i_Rst = 1'b0;
        model_reset();
        repeat (2) tick();
    endtask

    // monitor: pop and compare scoreboard entries when the DUT emits them
    always @(negedge i_Clk) begin
        logic [15:0] e;
        logic [19:0] w, got;
        if (bus.o_TX_DV === 1'b1) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %h required none", bus.o_TX_Byte);
            end else begin
                e = exp_tx.pop_front();
                if (bus.o_TX_Byte !== e) begin
                    errors++;
                    $display("FAIL tx_word got %h required %h", bus.o_TX_Byte, e);
                end
            end
        end
        if (o_Wr_Strobe === 1'b1) begin
            checks++;
            got = {o_Wr_Addr, (o_Wr_Addr < 4'd14) ? o_Regs[16*o_Wr_Addr +: 16] : 16'h0};
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got %h required none", got);
            end else begin
                w = exp_wr.pop_front();
                if (got !== w) begin
                    errors++;
                    $display("FAIL wr_event got %h required %h", got, w);
                end
            end
        end
        if (o_Frame_Err === 1'b1) obs_err++;
    end

    task automatic test_reset();
        i_Rst = 1'b1;
        model_reset();
        repeat (3) tick();
        checks++;
        if (o_Regs !== 224'h0) begin errors++; $display("FAIL reset_regs got %h required 0", o_Regs); end
        checks++;
        if (bus.o_TX_Byte !== 16'h0) begin errors++; $display("FAIL reset_tx_byte got %h required 0", bus.o_TX_Byte); end
        checks++;
        if ({bus.o_TX_DV, o_Wr_Strobe, o_Frame_Err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b required 000", {bus.o_TX_DV, o_Wr_Strobe, o_Frame_Err});
        end
        checks++;
        if (o_Wr_Addr !== 4'h0) begin errors++; $display("FAIL reset_wr_addr got %h required 0", o_Wr_Addr); end
        i_Rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        run_frame('{8'h03, 8'hBE, 8'hEF, 8'h00}, 3, 1'b0);
        checks++;
        if (o_Regs[63:48] !== 16'hBEEF) begin errors++; $display("FAIL wr_reg3 got %h required beef", o_Regs[63:48]); end
        run_frame('{8'h83, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        // reads reg 14 with two frames already counted -> 16'h0002 next frame
        run_frame('{8'h8E, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        run_frame('{8'h80, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (exp_tx.size() != 0) begin errors++; $display("FAIL wr_rd_tx_pending got %0d required 0", exp_tx.size()); end
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL wr_rd_err got %0d required %0d", obs_err, exp_err); end
    endtask

    task automatic test_short_write();
        run_frame('{8'h05, 8'h12, 8'h00, 8'h00}, 2, 1'b0);
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL short_err got %0d required %0d", obs_err, exp_err); end
        checks++;
        if (o_Regs[95:80] !== 16'h0) begin errors++; $display("FAIL short_reg5 got %h required 0", o_Regs[95:80]); end
        checks++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL short_pending got %0d/%0d required 0/0", exp_wr.size(), exp_tx.size());
        end
        // ERR_CNT visible in reg 14 high byte
        run_frame('{8'h8E, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        run_frame('{8'h80, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    endtask

    task automatic test_reserved();
        run_frame('{8'h91, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL rsv_err got %0d required %0d", obs_err, exp_err); end
        run_frame('{8'h8F, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        run_frame('{8'h80, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (exp_tx.size() != 0) begin errors++; $display("FAIL rsv_tx_pending got %0d required 0", exp_tx.size()); end
    endtask

    task automatic test_readonly();
        run_frame('{8'h0F, 8'h00, 8'h00, 8'h00}, 3, 1'b0);
        run_frame('{8'h8F, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL ro_err got %0d required %0d", obs_err, exp_err); end
        checks++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL ro_pending got %0d/%0d required 0/0", exp_wr.size(), exp_tx.size());
        end
    endtask

    task automatic test_extra_bytes();
        run_frame('{8'h01, 8'h11, 8'h22, 8'h33}, 4, 1'b0);
        checks++;
        if (o_Regs[31:16] !== 16'h1122) begin errors++; $display("FAIL extra_reg1 got %h required 1122", o_Regs[31:16]); end
        checks++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL extra_pending got %0d/%0d required 0/0", exp_wr.size(), exp_tx.size());
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        run_frame('{8'h06, 8'hCA, 8'hFE, 8'h00}, 3, 1'b1);
        checks++;
        if (o_Regs[111:96] !== 16'hCAFE) begin errors++; $display("FAIL late_reg6 got %h required cafe", o_Regs[111:96]); end
        checks++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            errors++; $display("FAIL late_pending got %0d/%0d required 0/0", exp_wr.size(), exp_tx.size());
        end
        ok = 1'b1;
        for (int i = 0; i < 14; i++) if (o_Regs[16*i +: 16] !== m_regs[i]) ok = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL regfile got %h required model", o_Regs); end
    endtask

    task automatic test_reset_mid_write();
        i_SPI_CS_n = 1'b0;
        repeat (4) tick();
        send_byte(8'h02);
        repeat (3) tick();
        send_byte(8'hAA);
        repeat (2) tick();
        i_Rst = 1'b1;
        model_reset();
        tick();
        checks++;
        if (o_Regs !== 224'h0) begin errors++; $display("FAIL rstmid_regs got %h required 0", o_Regs); end
        checks++;
        if ({bus.o_TX_DV, o_Wr_Strobe, o_Frame_Err, o_Wr_Addr, bus.o_TX_Byte} !== 23'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got %b%b%b %h %h required all 0",
                     bus.o_TX_DV, o_Wr_Strobe, o_Frame_Err, o_Wr_Addr, bus.o_TX_Byte);
        end
        i_Rst = 1'b0;
        repeat (4) tick();
        i_SPI_CS_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL rstmid_err got %0d required %0d", obs_err, exp_err); end
        run_frame('{8'h8E, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (exp_tx.size() != 0) begin errors++; $display("FAIL rstmid_tx_pending got %0d required 0", exp_tx.size()); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 255; i++) run_frame('{8'h80, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        run_frame('{8'h8E, 8'h00, 8'h00, 8'h00}, 1, 1'b0); // 16'h00FF
        run_frame('{8'h8E, 8'h00, 8'h00, 8'h00}, 1, 1'b0); // wrapped 16'h0000
        run_frame('{8'h80, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        checks++;
        if (exp_tx.size() != 0) begin errors++; $display("FAIL wrap_tx_pending got %0d required 0", exp_tx.size()); end
        checks++;
        if (m_frm_cnt !== 8'h02) begin errors++; $display("FAIL wrap_model_cnt got %h required 02", m_frm_cnt); end
    endtask

    initial begin
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        test_reset();
        test_write_read();
        test_short_write();
        test_reserved();
        test_readonly();
        test_extra_bytes();
        test_same_cycle();
        test_reset_mid_write();
        test_counter_wrap();
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
